// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
//   Single-clock sample FIFO for the audio datapath. Samples are stored in an
//   inferred block RAM with a registered read port. Provides full/empty,
//   programmable almost-full/almost-empty, an occupancy count and sticky
//   overflow/underflow flags. One read and one write per clock, sustained.
//
//   Build option:
//     SAMPLE_FIFO_FWFT_EN  defined   -> first-word-fall-through: the head word
//                                       is prefetched into dout, dout_valid is
//                                       a level, empty = !dout_valid, rd pops.
//                          undefined -> standard mode: dout is loaded one cycle
//                                       after an accepted rd, dout_valid pulses.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr, din    write strobe and data
//   rd         read strobe (standard) / head acknowledge (FWFT)
//   dout       read data register
//   dout_valid dout holds a valid word
//   full       count == DEPTH
//   afull      count >= AFULL_THRESH
//   empty      no word available to read
//   aempty     count <= AEMPTY_THRESH
//   count      words held, 0..DEPTH (includes the prefetched word in FWFT)
//   overflow   sticky: a write was dropped
//   underflow  sticky: a read was rejected
//   clr_err    synchronous clear of overflow/underflow (a new error wins)
// -----------------------------------------------------------------------------
module sample_fifo #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 512,
    parameter int AFULL_THRESH  = DEPTH - 16,
    parameter int AEMPTY_THRESH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     rd,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     afull,
    output logic                     empty,
    output logic                     aempty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_acc;     // read accepted from the user's view
    logic             wr_acc;     // write accepted into the RAM
    logic             ram_rd;     // RAM word moved into the dout register
    logic [CW-1:0]    count_next;
    logic             ovf_evt;
    logic             udf_evt;

`ifdef SAMPLE_FIFO_FWFT_EN
    logic ram_has;

    // Words still in RAM = count minus the word sitting in dout.
    assign ram_has = count > {{AW{1'b0}}, dout_valid};
    assign rd_acc  = rd && dout_valid;
    // Refill the output register whenever it is (or is about to become) empty.
    assign ram_rd  = ram_has && (!dout_valid || rd_acc);
    assign empty   = !dout_valid;
`else
    assign rd_acc  = rd && !empty;
    assign ram_rd  = rd_acc;
`endif

    // A read in the same cycle frees a slot, so a full FIFO still accepts wr.
    assign wr_acc  = wr && (!full || rd_acc);
    assign ovf_evt = wr && !wr_acc;
    assign udf_evt = rd && !rd_acc;

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // RAM array has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
                dout   <= mem[rd_ptr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
        end else begin
`ifdef SAMPLE_FIFO_FWFT_EN
            if (ram_rd) begin
                dout_valid <= 1'b1;
            end else if (rd_acc) begin
                dout_valid <= 1'b0;
            end
`else
            dout_valid <= rd_acc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            full   <= 1'b0;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            count  <= count_next;
            full   <= count_next == CW'(DEPTH);
            afull  <= count_next >= CW'(AFULL_THRESH);
            aempty <= count_next <= CW'(AEMPTY_THRESH);
        end
    end

`ifndef SAMPLE_FIFO_FWFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            empty <= 1'b1;
        end else begin
            empty <= count_next == '0;
        end
    end
`endif

    // A fresh error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ovf_evt || (overflow && !clr_err);
            underflow <= udf_evt || (underflow && !clr_err);
        end
    end

endmodule

// File: tb/tb_sample_fifo.sv
// -----------------------------------------------------------------------------
// tb_sample_fifo
//   Scoreboard bench for sample_fifo. The driver keeps a model of the FIFO
//   contents; each accepted read pushes the expected word into exp_q, and an
//   independent monitor pops and compares whenever the DUT presents a word.
//   Define SAMPLE_FIFO_FWFT_EN for both files to exercise FWFT mode.
// -----------------------------------------------------------------------------
module tb_sample_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 512;
    localparam int AF    = 496;
    localparam int AE    = 16;
`ifdef SAMPLE_FIFO_FWFT_EN
    localparam bit FWFT = 1'b1;
`else
    localparam bit FWFT = 1'b0;
`endif

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b1;
    logic             wr      = 1'b0;
    logic             rd      = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] din     = '0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid, full, afull, empty, aempty, overflow, underflow;
    logic [9:0]       count;

    sample_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .AFULL_THRESH(AF),
        .AEMPTY_THRESH(AE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .din(din), .rd(rd),
        .dout(dout), .dout_valid(dout_valid), .full(full), .afull(afull),
        .empty(empty), .aempty(aempty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];   // words the DUT must still present
    logic [WIDTH-1:0] ram_q[$];   // model of words held (RAM part in FWFT)
    bit               hv;         // model: FWFT output register holds a word
    logic [WIDTH-1:0] hd;
    bit               m_dv, m_ovf, m_udf;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int total();
        return ram_q.size() + (hv ? 1 : 0);
    endfunction

    task automatic model_reset();
        ram_q.delete();
        exp_q.delete();
        hv    = 1'b0;
        m_dv  = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic chk_status();
        int t;
        t = total();
        check("count", count, t);
        check("full", full, t == DEPTH);
        check("afull", afull, t >= AF);
        check("aempty", aempty, t <= AE);
        check("empty", empty, FWFT ? !hv : (t == 0));
        check("dout_valid", dout_valid, m_dv);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
    endtask

    task automatic chk_reset();
        check("rst_dout", dout, 0);
        check("rst_dout_valid", dout_valid, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", aempty, 1);
        check("rst_full", full, 0);
        check("rst_afull", afull, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
    endtask

    // Drive one cycle of stimulus, advance the model, then check status.
    task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
        bit rd_ok, wr_ok;
        wr = w; din = d; rd = r; clr_err = c;
`ifdef SAMPLE_FIFO_FWFT_EN
        rd_ok = r && hv;
`else
        rd_ok = r && (ram_q.size() > 0);
`endif
        wr_ok = w && (total() < DEPTH || rd_ok);
        m_ovf = (w && !wr_ok) || (m_ovf && !c);
        m_udf = (r && !rd_ok) || (m_udf && !c);
`ifdef SAMPLE_FIFO_FWFT_EN
        if (rd_ok) exp_q.push_back(hd);
        if (ram_q.size() > 0 && (!hv || rd_ok)) begin
            hd = ram_q.pop_front();
            hv = 1'b1;
        end else if (rd_ok) begin
            hv = 1'b0;
        end
        m_dv = hv;
`else
        if (rd_ok) exp_q.push_back(ram_q.pop_front());
        m_dv = rd_ok;
`endif
        if (wr_ok) ram_q.push_back(d);
        @(posedge clk);
        #1;
        chk_status();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1, 1'b0);
        idle(3);
    endtask

    // Monitor: compare every word the DUT hands out against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && dout_valid && (!FWFT || rd)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dout_unexpected: got=0x%0h expected=none at %0t", dout, $time);
            end else begin
                check("dout", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill to capacity.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
        check("fill_full", full, 1);
        check("fill_afull", afull, 1);
        check("fill_count", count, 512);

        // Overflow, error-wins-over-clear, then clear.
        step(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 512);
        step(1'b1, 16'hDEAD, 1'b0, 1'b1);
        check("ovf_err_wins", overflow, 1);
        step(1'b0, '0, 1'b0, 1'b1);
        check("ovf_clr", overflow, 0);

        // Simultaneous rd/wr at full.
        step(1'b1, 16'hBEEF, 1'b1, 1'b0);
        check("full_rdwr_count", count, 512);

        // Drain: 2..512 then 0xBEEF, checked by the monitor.
        drain(DEPTH);
        check("drain_count", count, 0);
        check("drain_empty", empty, 1);
        check("drain_all_out", exp_q.size(), 0);

        // Simultaneous rd/wr at empty.
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        check("empty_rdwr_udf", underflow, 1);
        check("empty_rdwr_count", count, 1);
        check("lat_dv1", dout_valid, 0);
        idle(1);
        check("lat_dv2", dout_valid, FWFT);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, '0, 1'b0, 1'b1);
        check("udf_clr", underflow, 0);

        // Wrap-around streaming at half occupancy.
        for (int i = 0; i < 256; i++) step(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++) step(1'b1, 16'(16'h2000 + i), 1'b1, 1'b0);
        check("wrap_count", count, 256);
        drain(256);
        check("wrap_all_out", exp_q.size(), 0);

        // Threshold crossings, one word at a time.
        for (int i = 1; i <= 496; i++) begin
            step(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
            if (i == 15) check("aempty_15", aempty, 1);
            if (i == 16) check("aempty_16", aempty, 1);
            if (i == 17) check("aempty_17", aempty, 0);
            if (i == 495) check("afull_495", afull, 0);
            if (i == 496) check("afull_496", afull, 1);
        end
        drain(496);

        // Reset mid-stream with 100 words held and rd active.
        for (int i = 0; i < 100; i++) step(1'b1, 16'(16'h6000 + i), 1'b0, 1'b0);
        wr = 1'b0;
        rd = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1 chk_reset();
        rd = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 16'h5A5A, 1'b0, 1'b0);
        idle(1);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        check("post_reset_count", count, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_fifo.md
# sample_fifo

Parametrised single-clock sample FIFO for the audio datapath, the general-purpose buffer between sample producers (ADC/track readers) and consumers (mixer, DAC serialiser). It stores WIDTH-bit samples in an inferred block RAM and provides true full/empty status, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. Reads and writes are single-cycle strobes, not edges, so back-to-back transfers run at one sample per clock.

## Interface
- WIDTH, 16: sample width in bits.
- DEPTH, 512: capacity in words; power of two, at least 4.
- AFULL_THRESH, DEPTH-16: afull asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 16: aempty asserts when count <= AEMPTY_THRESH.

- clk  input  1  system clock, 100 MHz; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised to clk upstream.
- wr  input  1  write strobe; one word per cycle while high.
- din  input  WIDTH  write data, sampled when wr is high.
- rd  input  1  read strobe (standard mode) or acknowledge of the head word (FWFT mode).
- dout  output  WIDTH  read data.
- dout_valid  output  1  dout holds a valid word (see Timing).
- full  output  1  count == DEPTH.
- afull  output  1  count >= AFULL_THRESH.
- empty  output  1  no word is available to read.
- aempty  output  1  count <= AEMPTY_THRESH.
- count  output  $clog2(DEPTH)+1  words held, 0..DEPTH.
- overflow  output  1  sticky; a write was dropped.
- underflow  output  1  sticky; a read was rejected.
- clr_err  input  1  synchronous clear of overflow and underflow.

## Operation
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0; there is no comparison against DEPTH.
- A write is accepted when wr && (!full || rd_accepted). An accepted write stores din at wr_ptr and increments wr_ptr.
- A read is accepted when rd && !empty. An accepted read increments rd_ptr.
- count updates as +1 for a write only, -1 for a read only, and is unchanged when both or neither are accepted.
- When full with rd and wr in the same cycle, both are accepted and count stays DEPTH.
- When empty with rd and wr in the same cycle, only the write is accepted and underflow is set.
- A wr while full, without an accepted rd, drops the word and sets overflow. A rd while empty is ignored and sets underflow.
- clr_err clears both sticky flags. A new error in the same cycle as clr_err wins, so the flag stays set.
- Reset is asynchronous and takes effect mid-transfer. All stored words are discarded; RAM contents are not cleared.

## Timing
- Reset values: dout = 0, dout_valid = 0, empty = 1, aempty = 1, full = 0, afull = 0, count = 0, overflow = 0, underflow = 0, both pointers = 0.
- count and all flags are registered and reflect accepted operations from the cycle after the clock edge on which those operations were accepted.
- Standard mode: dout is registered. It presents the word 1 cycle after the accepted read, and dout_valid pulses high for exactly that cycle. dout holds its value when no read is accepted.
- Write-to-read turnaround into an empty FIFO is 1 cycle: empty falls the cycle after the write, and a rd in that cycle is accepted.
- Throughput is one read and one write per cycle, sustained.

## Configuration
- SAMPLE_FIFO_FWFT_EN: when defined, the FIFO runs in first-word-fall-through mode.
  - The head word is prefetched into the output register, and dout_valid stays high while dout holds it.
  - empty = !dout_valid. An accepted rd pops the head; the next word appears on the following cycle if one is available, otherwise dout_valid falls.
  - A write into an empty FIFO raises dout_valid 2 cycles later.
  - count includes the prefetched word, and total capacity remains DEPTH.
- When the macro is undefined, standard mode applies as specified above, and the prefetch logic is absent.

## Test plan
- Fill/drain: after reset, write 0x0001..0x0200 (512 words). Check full = 1, afull = 1 and count = 512. Read all 512 and check data in order, dout_valid once per read, empty = 1 and count = 0 at the end.
- Overflow: while full, write 0xDEAD. Check overflow = 1, count = 512, and 0xDEAD is never read. Pulse clr_err and check overflow = 0.
- Simultaneous access: at full, apply rd and wr of 0xBEEF for 1 cycle and check count = 512. At empty, apply rd and wr and check underflow = 1, count = 1, and the next read returns the written word.
- Wrap-around: stream 2000 words with rd and wr high together at half occupancy. Check the data order is intact across multiple pointer wraps and count stays constant.
- Thresholds: step count through 15, 16, 17 and 495, 496 one word at a time. Check aempty = 1, 1, 0 and afull = 0, 1, each updating one cycle after the write.
- Reset mid-stream: drop rst_n with 100 words held and rd active. Check all outputs return to their reset values immediately, and the next write/read pair returns the new word. Repeat the whole test plan with SAMPLE_FIFO_FWFT_EN defined, checking the 2-cycle dout_valid latency.
